// File: rtl/pattern_det_pkg.sv
// Shared definitions for the serial pattern detector: state-width helper and
// overlap-mode encodings.
package pattern_det_pkg;

   localparam logic OVL_ON  = 1'b1;
   localparam logic OVL_OFF = 1'b0;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/pattern_detector_if.sv
// Serial-input / detect-output bundle of the pattern detector. The master drives
// the sample stream and pattern loads; the slave (detector) returns detections.
interface pattern_detector_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   import pattern_det_pkg::*;
   localparam int SW = clog2(PAT_W);

   logic             en;
   logic             x;
   logic             overlap;
   logic             pat_load;
   logic [PAT_W-1:0] pat_in;
   logic             y;
   logic             y_q;
   logic [SW-1:0]    state;
   logic [CNT_W-1:0] cnt;
   logic             cnt_ovf;

   modport master (
      output en, x, overlap, pat_load, pat_in,
      input  y, y_q, state, cnt, cnt_ovf
   );

   modport slave (
      input  en, x, overlap, pat_load, pat_in,
      output y, y_q, state, cnt, cnt_ovf
   );

endinterface

// File: rtl/pattern_next_state.sv
// Combinational KMP step: from the current prefix length, the recent history
// and the incoming bit, produce the next prefix length, match and pattern border.
module pattern_next_state
   import pattern_det_pkg::*;
#(
   parameter int  PAT_W = 4,
   localparam int SW    = clog2(PAT_W)
) (
   input  logic [PAT_W-1:0] pat,
   input  logic [PAT_W-2:0] hist,
   input  logic [SW-1:0]    k,
   input  logic             b,
   output logic [SW-1:0]    next_k,
   output logic             match,
   output logic [SW-1:0]    border
);

   logic [PAT_W-1:0] seq;
   logic [PAT_W-1:0] ones;
   logic [PAT_W-1:0] mask;

   // seq[j-1:0] holds the last j accepted bits, oldest at the top, aligned with
   // the pattern's first j bits after shifting pat down by PAT_W-j.
   always_comb begin
      seq    = {hist, b};
      ones   = '1;
      mask   = '0;
      next_k = '0;
      border = '0;
      match  = (k == SW'(PAT_W - 1)) && (b == pat[0]);
      for (int j = 1; j < PAT_W; j++) begin
         mask = ones >> (PAT_W - j);
         if ((j <= int'(k) + 1) && ((seq & mask) == ((pat >> (PAT_W - j)) & mask)))
            next_k = SW'(j);
         if ((pat & mask) == ((pat >> (PAT_W - j)) & mask))
            border = SW'(j);
      end
   end

endmodule

// File: rtl/pattern_detector.sv
// Run-time reloadable serial pattern detector with overlap control, Mealy and
// registered detect outputs, and a saturating match counter.
module pattern_detector
   import pattern_det_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
   parameter int               CNT_W   = 8
) (
   input logic               clk,
   input logic               reset,
   pattern_detector_if.slave bus
);

   localparam int SW = clog2(PAT_W);

   logic [PAT_W-1:0] pat_q,   pat_d;
   logic [PAT_W-2:0] hist_q,  hist_d;
   logic [SW-1:0]    state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             ovf_q,   ovf_d;
   logic             y_q,     y_d;

   logic [SW-1:0]    nxt_k;
   logic [SW-1:0]    border;
   logic             match;
   logic [PAT_W-1:0] seq;
   logic             y;

   pattern_next_state #(.PAT_W(PAT_W)) u_next (
      .pat    (pat_q),
      .hist   (hist_q),
      .k      (state_q),
      .b      (bus.x),
      .next_k (nxt_k),
      .match  (match),
      .border (border)
   );

   assign seq = {hist_q, bus.x};
   assign y   = bus.en & ~bus.pat_load & ~reset & match;

   // A pattern load outranks sampling: the bit on that edge is dropped.
   always_comb begin
      pat_d   = pat_q;
      hist_d  = hist_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      y_d     = 1'b0;
      if (bus.pat_load) begin
         pat_d   = bus.pat_in;
         hist_d  = '0;
         state_d = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else if (bus.en) begin
         y_d     = y;
         hist_d  = seq[PAT_W-2:0];
         state_d = nxt_k;
         if (match) begin
            if (cnt_q == '1) ovf_d = 1'b1;
            else             cnt_d = cnt_q + 1'b1;
            if (bus.overlap == OVL_OFF) begin
               hist_d  = '0;
               state_d = '0;
            end else begin
               state_d = border;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q   <= PATTERN;
         hist_q  <= '0;
         state_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         y_q     <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         y_q     <= y_d;
      end
   end

   assign bus.y       = y;
   assign bus.y_q     = y_q;
   assign bus.state   = state_q;
   assign bus.cnt     = cnt_q;
   assign bus.cnt_ovf = ovf_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector: two instances (8-bit and 2-bit counters) fed the
// same stream, checked against a queue-based model of the matching rules.
module tb_pattern_detector;
   import pattern_det_pkg::*;

   localparam int         PAT_W = 4;
   localparam logic [3:0] PAT0  = 4'b1001;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(8)) if_a ();
   pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(2)) if_b ();

   assign if_b.en       = if_a.en;
   assign if_b.x        = if_a.x;
   assign if_b.overlap  = if_a.overlap;
   assign if_b.pat_load = if_a.pat_load;
   assign if_b.pat_in   = if_a.pat_in;

   pattern_detector #(.PAT_W(PAT_W), .PATTERN(PAT0), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .bus(if_a));
   pattern_detector #(.PAT_W(PAT_W), .PATTERN(PAT0), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .bus(if_b));

   // Model: accepted bits since last restart, current pattern, unbounded match count.
   bit         acc[$];
   logic [3:0] mp;
   int         mcnt;
   bit         movf_a, movf_b, myq;

   int n_cmp = 0;
   int n_bad = 0;
   int obs_y, obs_yq, obs_state;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int suffix_len();
      for (int k = PAT_W - 1; k > 0; k--) begin
         if (acc.size() >= k) begin
            bit ok = 1'b1;
            for (int i = 0; i < k; i++)
               if (acc[acc.size() - k + i] != mp[PAT_W-1-i]) ok = 1'b0;
            if (ok) return k;
         end
      end
      return 0;
   endfunction

   function automatic bit would_match(input bit b);
      if (acc.size() + 1 < PAT_W) return 1'b0;
      for (int i = 0; i < PAT_W - 1; i++)
         if (acc[acc.size() - (PAT_W - 1) + i] != mp[PAT_W-1-i]) return 1'b0;
      return b == mp[0];
   endfunction

   task automatic model_reset();
      acc.delete();
      mp     = PAT0;
      mcnt   = 0;
      movf_a = 1'b0;
      movf_b = 1'b0;
      myq    = 1'b0;
   endtask

   task automatic check_regs();
      chk("state_a", int'(if_a.state), suffix_len());
      chk("state_b", int'(if_b.state), suffix_len());
      chk("cnt_a", int'(if_a.cnt), (mcnt > 255) ? 255 : mcnt);
      chk("cnt_b", int'(if_b.cnt), (mcnt > 3) ? 3 : mcnt);
      chk("ovf_a", int'(if_a.cnt_ovf), int'(movf_a));
      chk("ovf_b", int'(if_b.cnt_ovf), int'(movf_b));
      chk("yq_a", int'(if_a.y_q), int'(myq));
      chk("yq_b", int'(if_b.y_q), int'(myq));
   endtask

   task automatic step(input bit en_i, input bit x_i, input bit ov_i,
                       input bit pl_i, input logic [3:0] pin_i);
      bit em;
      @(negedge clk);
      if_a.en       = en_i;
      if_a.x        = x_i;
      if_a.overlap  = ov_i ? OVL_ON : ~OVL_ON;
      if_a.pat_load = pl_i;
      if_a.pat_in   = pin_i;
      #1;
      em = en_i && !pl_i && would_match(x_i);
      chk("y_a", int'(if_a.y), int'(em));
      chk("y_b", int'(if_b.y), int'(em));
      obs_y = int'(if_a.y);
      @(posedge clk);
      #1;
      if (pl_i) begin
         mp = pin_i;
         acc.delete();
         mcnt   = 0;
         movf_a = 1'b0;
         movf_b = 1'b0;
         myq    = 1'b0;
      end else if (en_i) begin
         if (em) begin
            if (mcnt >= 255) movf_a = 1'b1;
            if (mcnt >= 3)   movf_b = 1'b1;
            mcnt++;
         end
         acc.push_back(x_i);
         if (em && !ov_i) acc.delete();
         while (acc.size() > PAT_W) void'(acc.pop_front());
         myq = em;
      end else begin
         myq = 1'b0;
      end
      check_regs();
      obs_state = int'(if_a.state);
      obs_yq    = int'(if_a.y_q);
   endtask

   // Reset is pulsed between edges while a sample is being presented.
   task automatic pulse_reset(input bit x_i);
      @(negedge clk);
      if_a.en       = 1'b1;
      if_a.x        = x_i;
      if_a.pat_load = 1'b0;
      #1;
      chk("y_pre_rst", int'(if_a.y), int'(would_match(x_i)));
      obs_y = int'(if_a.y);
      reset = 1'b1;
      #1;
      model_reset();
      chk("y_in_rst_a", int'(if_a.y), 0);
      chk("y_in_rst_b", int'(if_b.y), 0);
      check_regs();
      if_a.en = 1'b0;
      reset   = 1'b0;
   endtask

   bit t1_x [7] = '{1, 0, 0, 1, 0, 0, 1};
   bit t1_y [7] = '{0, 0, 0, 1, 0, 0, 1};
   bit t2_y [7] = '{0, 0, 0, 1, 0, 0, 0};
   bit t3_x [5] = '{1, 1, 1, 0, 1};
   int t3_s [5] = '{1, 2, 2, 3, 0};
   int t5_c [5] = '{1, 2, 3, 3, 3};
   int t5_o [5] = '{0, 0, 0, 1, 1};

   initial begin
      reset         = 1'b1;
      if_a.en       = 1'b1;
      if_a.x        = 1'b1;
      if_a.overlap  = OVL_ON;
      if_a.pat_load = 1'b0;
      if_a.pat_in   = '0;
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_y", int'(if_a.y), 0);
      chk("rst_state", int'(if_a.state), 0);
      chk("rst_cnt", int'(if_a.cnt), 0);
      chk("rst_ovf", int'(if_a.cnt_ovf), 0);
      chk("rst_yq", int'(if_a.y_q), 0);
      if_a.en = 1'b0;
      reset   = 1'b0;

      // Default pattern, overlapping
      for (int i = 0; i < 7; i++) begin
         step(1, t1_x[i], 1, 0, '0);
         chk("t1_y", obs_y, int'(t1_y[i]));
         chk("t1_yq", obs_yq, int'(t1_y[i]));
      end
      chk("t1_cnt", int'(if_a.cnt), 2);

      // Non-overlapping restart
      step(0, 0, 1, 1, PAT0);
      for (int i = 0; i < 7; i++) begin
         step(1, t1_x[i], 0, 0, '0);
         chk("t2_y", obs_y, int'(t2_y[i]));
         if (i == 3) chk("t2_state", obs_state, 0);
      end
      chk("t2_cnt", int'(if_a.cnt), 1);

      // en gaps hold the partial match
      step(0, 0, 1, 1, PAT0);
      step(1, 1, 1, 0, '0);
      step(1, 0, 1, 0, '0);
      for (int i = 0; i < 3; i++) begin
         step(0, i[0], 1, 0, '0);
         chk("t4_hold", obs_state, 2);
      end
      step(1, 0, 1, 0, '0);
      step(1, 1, 1, 0, '0);
      chk("t4_y", obs_y, 1);
      chk("t4_cnt", int'(if_a.cnt), 1);

      // Async reset mid-pattern
      step(0, 0, 1, 1, PAT0);
      step(1, 1, 1, 0, '0);
      step(1, 0, 1, 0, '0);
      step(1, 0, 1, 0, '0);
      pulse_reset(1);
      chk("t6_y_pre", obs_y, 1);
      step(1, 1, 1, 0, '0);
      step(1, 0, 1, 0, '0);
      step(1, 0, 1, 0, '0);
      step(1, 1, 1, 0, '0);
      chk("t6_y_after", obs_y, 1);

      // Counter saturation on the 2-bit instance
      step(0, 0, 1, 1, PAT0);
      step(1, 1, 1, 0, '0);
      for (int m = 0; m < 5; m++) begin
         step(1, 0, 1, 0, '0);
         step(1, 0, 1, 0, '0);
         step(1, 1, 1, 0, '0);
         chk("t5_cnt_b", int'(if_b.cnt), t5_c[m]);
         chk("t5_ovf_b", int'(if_b.cnt_ovf), t5_o[m]);
      end
      chk("t5_cnt_a", int'(if_a.cnt), 5);
      step(0, 0, 1, 1, PAT0);
      chk("t5_ovf_clr", int'(if_b.cnt_ovf), 0);

      // New pattern 1101, KMP fallback
      step(0, 0, 0, 1, 4'b1101);
      for (int i = 0; i < 5; i++) begin
         step(1, t3_x[i], 0, 0, '0);
         chk("t3_state", obs_state, t3_s[i]);
         chk("t3_y", obs_y, (i == 4) ? 1 : 0);
      end

      // Load wins over a completing sample
      step(1, 1, 1, 0, '0);
      step(1, 1, 1, 0, '0);
      step(1, 0, 1, 0, '0);
      step(1, 1, 1, 1, PAT0);
      chk("t7_y", obs_y, 0);
      chk("t7_cnt", int'(if_a.cnt), 0);
      chk("t7_state", obs_state, 0);
      step(1, 1, 1, 0, '0);
      step(1, 0, 1, 0, '0);
      step(1, 0, 1, 0, '0);
      step(1, 1, 1, 0, '0);
      chk("t7_newpat", obs_y, 1);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = $urandom_range(0, 199);
         if (r == 0)
            pulse_reset(1'($urandom));
         else
            step($urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
                 r < 4, 4'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
